// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: decodes a servo-style PWM input. It measures the high time and the
// rise-to-rise period in clk cycles and presents each completed frame on a valid/ready
// output. It also flags lost signal, out-of-range pulses and frames dropped while the
// output register was still full.
// Optional build macro: SERVO_CAP_GLITCH_FILTER_EN inserts a FILTER_LEN-sample glitch
// filter after the synchroniser. Each edge is then delayed by FILTER_LEN cycles.
module servo_pwm_capture #(
  parameter int CNT_W      = 21,
  parameter int TIMEOUT    = 600000,
  parameter int PW_MIN     = 1600,
  parameter int PW_MAX     = 66000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             range_err,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             signal_lost
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  if (FILTER_LEN < 1 || TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : g_param_check
    $error("servo_pwm_capture: FILTER_LEN must be >= 1 and TIMEOUT must fit in CNT_W bits");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + CNT_W'(1);
  endfunction

  function automatic logic out_of_range(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(PW_MIN)) || (v > CNT_W'(PW_MAX));
  endfunction

  logic sync_p0, sync_p1;
  logic lvl, lvl_d, rise, fall;

  // ---- stage p0/p1: synchroniser ----
  // Two-flop synchroniser. It is left unreset, so a level already present at reset is never seen as an edge.
  always_ff @(posedge clk) begin
    sync_p0 <= pwm_in;
    sync_p1 <= sync_p0;
  end

`ifdef SERVO_CAP_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILTER_LEN + 1);
  logic [FC_W-1:0] flt_cnt;
  logic            flt_lvl;

  // Filtered level follows the synchronised level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (sync_p1 == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FC_W'(FILTER_LEN - 1)) begin
      flt_lvl <= sync_p1;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FC_W'(1);
    end
  end

  assign lvl = flt_lvl;
`else
  assign lvl = sync_p1;
`endif

  // Delayed copy of the level for edge detection. It is unreset for the same reason as the synchroniser.
  always_ff @(posedge clk) begin
    lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // ---- frame FSM and counters ----
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, hi_lat;
  logic             timeout_hit, cnt_start, hi_cap, frame_done, load;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Timeout wins over a coincident edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = HIGH;
      HIGH:    if (cnt == TIMEOUT_C) state_nxt = IDLE;
               else if (fall)        state_nxt = LOW;
      LOW:     if (cnt == TIMEOUT_C) state_nxt = IDLE;
               else if (rise)        state_nxt = HIGH;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode for the counter, high-time latch and frame completion.
  always_comb begin
    timeout_hit = (state != IDLE) && (cnt == TIMEOUT_C);
    cnt_start   = rise && ((state == IDLE) || ((state == LOW) && !timeout_hit));
    hi_cap      = (state == HIGH) && fall && !timeout_hit;
    frame_done  = (state == LOW) && rise && !timeout_hit;
  end

  // Cycle counter. It restarts at 1 on each accepted rise and saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst)                               cnt <= '0;
    else if (cnt_start)                    cnt <= CNT_W'(1);
    else if (state == IDLE || timeout_hit) cnt <= '0;
    else                                   cnt <= sat_inc(cnt);
  end

  // High-time latch. It is always written on a fall before any frame can complete.
  always_ff @(posedge clk) begin
    if (hi_cap) hi_lat <= cnt;
  end

  // ---- output register ----
  assign load = frame_done && (!meas_valid || meas_ready);

  // Output handshake, overrun pulse and sticky lost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      meas_valid <= load || (meas_valid && !meas_ready);
      overrun    <= frame_done && !load;
      if (load)             signal_lost <= 1'b0;
      else if (timeout_hit) signal_lost <= 1'b1;
    end
  end

  // Frame data. It is held stable until the next frame loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      range_err  <= 1'b0;
    end else if (load) begin
      high_cnt   <= hi_lat;
      period_cnt <= cnt;
      range_err  <= out_of_range(hi_lat);
    end
  end

endmodule
